// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and big-endian lane helpers.
package dmem_pkg;

  localparam logic [1:0] DSIZE_WORD = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_BYTE = 2'b10;
  localparam logic [1:0] DSIZE_RSVD = 2'b11;

  localparam int unsigned LANE_BITS = 8;
  localparam int unsigned LANES     = 4;

  // Byte offset of each big-endian halfword within a word.
  localparam logic [1:0] HALF_HI_OFFS = 2'd0;
  localparam logic [1:0] HALF_LO_OFFS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte-enable bit 3 covers bits [31:24], i.e. byte offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] dsize, input logic [1:0] offs);
    logic [3:0] mask;
    case (dsize)
      DSIZE_WORD: mask = 4'b1111;
      DSIZE_HALF: mask = (offs == HALF_LO_OFFS) ? 4'b0011 : 4'b1100;
      DSIZE_BYTE: mask = 4'b1000 >> offs;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic [LANES-1:0]     i_be,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [2**ADDR_BITS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][LANE_BITS*i +: LANE_BITS] <= i_wdata[LANE_BITS*i +: LANE_BITS];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accepts one load/store, waits WAIT_CYCLES, then
// returns a one-cycle response with big-endian lane steering and load extension.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_dsize,
  input  logic        req_loadext,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_BITS = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_BITS'(WAIT_CYCLES - 1);

  state_t              r_state, w_state_next;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_next;
  logic                w_capture, w_enter_resp, w_commit;

  logic        r_write, r_loadext, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_dsize;

  logic        w_op_write, w_op_err;
  logic [31:0] w_op_addr, w_op_wdata, w_wdata_rep;
  logic [1:0]  w_op_dsize;
  logic [3:0]  w_be;
  logic [31:0] w_ram_q, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_next = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_BITS'(1);
        end
      end
      RESP: begin
        resp_valid   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_enter_resp ? w_op_err : 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_write   <= req_write;
      r_addr    <= req_addr;
      r_wdata   <= req_wdata;
      r_dsize   <= req_dsize;
      r_loadext <= req_loadext;
    end
  end

  // With zero wait states the commit edge is the capture edge, so the live
  // request feeds the array before the holding registers are loaded.
  assign w_op_write = (r_state == IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_op_dsize = (r_state == IDLE) ? req_dsize : r_dsize;

  assign w_op_err = (w_op_dsize == DSIZE_RSVD)
                  || ((w_op_dsize == DSIZE_HALF) && w_op_addr[0])
                  || ((w_op_dsize == DSIZE_WORD) && (w_op_addr[1:0] != 2'b00))
                  || ((w_op_addr >> (ADDR_BITS + 2)) != 32'd0);

  assign w_commit = w_enter_resp && !reset;

  always_comb begin
    w_wdata_rep = w_op_wdata;
    if (w_op_dsize == DSIZE_HALF) w_wdata_rep = {2{w_op_wdata[15:0]}};
    if (w_op_dsize == DSIZE_BYTE) w_wdata_rep = {4{w_op_wdata[7:0]}};
  end

  assign w_be = (w_commit && w_op_write && !w_op_err) ?
                lane_mask(w_op_dsize, w_op_addr[1:0]) : 4'b0000;

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .i_clk  (clock),
    .i_be   (w_be),
    .i_re   (w_commit && !w_op_write),
    .i_addr (w_op_addr[ADDR_BITS+1:2]),
    .i_wdata(w_wdata_rep),
    .o_rdata(w_ram_q)
  );

  always_comb begin
    unique case (r_addr[1:0])
      2'd0:    w_byte = w_ram_q[31:24];
      2'd1:    w_byte = w_ram_q[23:16];
      2'd2:    w_byte = w_ram_q[15:8];
      default: w_byte = w_ram_q[7:0];
    endcase
    w_half = (r_addr[1:0] == HALF_LO_OFFS) ? w_ram_q[15:0] : w_ram_q[31:16];
    w_load = w_ram_q;
    if (r_dsize == DSIZE_HALF) w_load = {{16{r_loadext & w_half[15]}}, w_half};
    if (r_dsize == DSIZE_BYTE) w_load = {{24{r_loadext & w_byte[7]}}, w_byte};
  end

  assign resp_rdata = (resp_valid && !r_err && !r_write) ? w_load : 32'd0;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) checked against a
// byte-addressed big-endian memory model.
module tb_dmem_responder;

  localparam int unsigned AW = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        a_valid = 0, a_ready, a_write = 0, a_ext = 0, a_rvalid, a_rerr;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic [1:0]  a_dsize = 0;
  logic        b_valid = 0, b_ready, b_write = 0, b_ext = 0, b_rvalid, b_rerr;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
  logic [1:0]  b_dsize = 0;

  dmem_responder #(.ADDR_BITS(AW), .WAIT_CYCLES(2)) u_dut_a (
    .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata), .req_dsize(a_dsize),
    .req_loadext(a_ext), .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_rerr)
  );

  dmem_responder #(.ADDR_BITS(AW), .WAIT_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata), .req_dsize(b_dsize),
    .req_loadext(b_ext), .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_rerr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
  } exp_t;

  exp_t        qa[$], qb[$];
  logic [7:0]  mem_a[int unsigned];
  logic [7:0]  mem_b[int unsigned];
  int          checks = 0, errors = 0;
  int          b_last = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory as individual bytes, byte address a holds the most significant byte.
  function automatic void model(input bit which, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz, input bit ext,
                                output logic [31:0] rd, output logic err);
    int          n;
    logic [63:0] v;
    n   = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    err = (sz == 2'b11) || ((a % n) != 0) || (a >= (32'd1 << (AW + 2)));
    rd  = 32'd0;
    if (err) return;
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      int unsigned ba;
      logic [7:0]  b;
      ba = a + i;
      if (wr) begin
        b = 8'(wd >> (8 * (n - 1 - i)));
        if (which) mem_b[ba] = b; else mem_a[ba] = b;
      end else begin
        if (which) b = mem_b.exists(ba) ? mem_b[ba] : 8'h00;
        else       b = mem_a.exists(ba) ? mem_a[ba] : 8'h00;
        v = (v << 8) | {56'd0, b};
      end
    end
    if (!wr) begin
      if (ext && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  // Called at a negedge; returns at a negedge after the handshake edge.
  task automatic issue(input bit which, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input bit ext,
                       input bit push, input bit use_k, input logic [31:0] k_rd,
                       input bit k_err, input bit hold);
    int          t;
    logic [31:0] rd;
    logic        er;
    t = 0;
    if (which) begin
      b_valid = 1; b_write = wr; b_addr = a; b_wdata = wd; b_dsize = sz; b_ext = ext;
    end else begin
      a_valid = 1; a_write = wr; a_addr = a; a_wdata = wd; a_dsize = sz; a_ext = ext;
    end
    while (!(which ? b_ready : a_ready) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!(which ? b_ready : a_ready)) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut=%0d: req_ready stayed 0, expected 1", which);
      if (which) b_valid = 0; else a_valid = 0;
      return;
    end
    if (push) begin
      model(which, wr, a, wd, sz, ext, rd, er);
      if (use_k) begin
        rd = k_rd;
        er = k_err;
      end
      if (which) qb.push_back('{rdata: rd, err: er, hs: cyc});
      else       qa.push_back('{rdata: rd, err: er, hs: cyc});
    end
    @(negedge clock);
    if (!hold) begin
      if (which) begin
        b_valid = 0; b_addr = $urandom; b_wdata = $urandom;
      end else begin
        a_valid = 0; a_addr = $urandom; a_wdata = $urandom; a_dsize = 2'($urandom);
      end
    end
  endtask

  task automatic rand_op(input bit which, input bit hold);
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 15) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
    issue(which, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1, 0, 0, 0, hold);
  endtask

  always @(negedge clock) begin
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_resp: resp_valid 1 with no outstanding request");
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_err", a_rerr, e.err);
        chk("a_latency", cyc, e.hs + 3);
        chk("a_ready_in_resp", a_ready, 0);
      end
    end
  end

  always @(negedge clock) begin
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_resp: resp_valid 1 with no outstanding request");
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_err", b_rerr, e.err);
        chk("b_latency", cyc, e.hs + 1);
        chk("b_ready_in_resp", b_ready, 0);
        if (b_last >= 0) chk("b_spacing", cyc - b_last, 2);
        b_last = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_err", a_rerr, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_rvalid", b_rvalid, 0);
    reset = 0;
    @(negedge clock);

    for (int w = 0; w < 64; w++) issue(0, 1, 32'(4 * w), $urandom, 2'b00, 0, 1, 0, 0, 0, 0);

    issue(0, 1, 32'h10, 32'hA1B2C3D4, 2'b00, 0, 1, 1, 32'h0, 0, 0);
    issue(0, 0, 32'h11, 32'h0, 2'b10, 1, 1, 1, 32'hFFFFFFB2, 0, 0);
    issue(0, 0, 32'h11, 32'h0, 2'b10, 0, 1, 1, 32'h000000B2, 0, 0);
    issue(0, 0, 32'h12, 32'h0, 2'b01, 1, 1, 1, 32'hFFFFC3D4, 0, 0);
    issue(0, 0, 32'h10, 32'h0, 2'b00, 1, 1, 1, 32'hA1B2C3D4, 0, 0);
    issue(0, 1, 32'h13, 32'h5A, 2'b10, 0, 1, 1, 32'h0, 0, 0);
    issue(0, 0, 32'h10, 32'h0, 2'b00, 0, 1, 1, 32'hA1B2C35A, 0, 0);
    issue(0, 0, 32'h11, 32'h0, 2'b01, 1, 1, 1, 32'h0, 1, 0);
    issue(0, 1, 32'h12, 32'hFFFFFFFF, 2'b00, 0, 1, 1, 32'h0, 1, 0);
    issue(0, 0, 32'h10, 32'h0, 2'b00, 0, 1, 1, 32'hA1B2C35A, 0, 0);
    issue(0, 0, 32'h10, 32'h0, 2'b11, 0, 1, 1, 32'h0, 1, 0);
    issue(0, 0, 32'h1000, 32'h0, 2'b00, 0, 1, 1, 32'h0, 1, 0);

    // Store abandoned by reset while still waiting.
    issue(0, 1, 32'h20, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 0);
    reset = 1;
    @(negedge clock);
    chk("midrst_ready", a_ready, 1);
    chk("midrst_rvalid", a_rvalid, 0);
    chk("midrst_rdata", a_rdata, 0);
    chk("midrst_err", a_rerr, 0);
    reset = 0;
    issue(0, 0, 32'h20, 32'h0, 2'b00, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) rand_op(0, 0);

    for (int w = 0; w < 64; w++) issue(1, 1, 32'(4 * w), $urandom, 2'b00, 0, 1, 0, 0, 0, 1);
    issue(1, 0, 32'h40, 32'h0, 2'b00, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 150; i++) rand_op(1, 1);
    b_valid = 0;

    for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clock);
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d responses outstanding, expected 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers load/store requests issued by the pipeline's memory stage.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a single-cycle response.
- Performs byte/half/word access with big-endian lane selection and sign/zero extension of load data.
- Sits between mem_unit and the storage array, so the memory stage sees a realistic multi-cycle memory it must stall on.

Parameters:
- ADDR_BITS, 10, log2 of array depth in 32-bit words (array holds 2^ADDR_BITS words).
- WAIT_CYCLES, 2, wait states between acceptance and response (0 allowed).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_dsize  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved
- req_loadext  input  1  1 = sign-extend load data, 0 = zero-extend
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  32  load result, right-justified and extended; 0 for stores and errors
- resp_err  output  1  request faulted; valid only with resp_valid

Behaviour:
- Clock and reset: clock is named clock and reset is named reset. One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid=1, capture write, addr, wdata, dsize and loadext into holding registers. If WAIT_CYCLES>0 go to BUSY with counter=WAIT_CYCLES-1, else go to RESP. After capture, request inputs are don't-care.
  - BUSY: req_ready=0. The counter decrements each cycle; when it is 0, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
- Latency: a request accepted on edge N gives resp_valid=1 in the cycle after edge N+WAIT_CYCLES+1. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Commit point: the array write and the read-data capture both happen on the edge that enters RESP. resp_rdata and resp_err are registered at that edge and return to 0 when leaving RESP.
- Endianness (big-endian):
  - Byte offset 0 is array bits [31:24].
  - Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Stores: write only the addressed lanes (byte enables); other lanes are unchanged.
- Loads: extract the lanes, right-justify, then sign- or zero-extend per the captured loadext. A word load ignores loadext.
- Error (resp_err=1, no array write, resp_rdata=0) when any of these holds:
  - dsize=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:ADDR_BITS+2]≠0.
- Reset mid-operation: in IDLE, BUSY or RESP, reset forces IDLE and clears outputs. A store still in BUSY is abandoned with no array write. A store already committed (in RESP) remains written.
- req_valid arriving in BUSY or RESP is ignored (req_ready=0). The requester must hold it until accepted.

Decomposition:
- Shared package dmem_pkg:
  - dsize encodings DSIZE_WORD/HALF/BYTE/RSVD;
  - state enum IDLE/BUSY/RESP;
  - helper constants for lane offsets.
- One sub-module, dmem_array: a single-port, 2^ADDR_BITS × 32 synchronous RAM with a 4-bit byte-enable write and registered read.
- Lane steering, extension, error detection and the FSM stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2: store word 0xA1B2C3D4 at 0x10 accepted at edge N -> resp_valid=1 only in the cycle after edge N+3, resp_err=0, resp_rdata=0, req_ready=0 until the cycle after RESP.
- After the above store, load byte at 0x11:
  - loadext=1 -> resp_rdata=0xFFFFFFB2;
  - loadext=0 -> 0x000000B2;
  - load half at 0x12 with loadext=1 -> 0xFFFFC3D4;
  - load word at 0x10 -> 0xA1B2C3D4.
- Store byte wdata=0x0000005A at 0x13, then load word at 0x10 -> 0xA1B2C35A (other lanes preserved).
- Errors:
  - load half at 0x11 -> resp_err=1, rdata=0;
  - store word 0xFFFFFFFF at 0x12 -> resp_err=1, and a later word load at 0x10 still returns 0xA1B2C35A;
  - dsize=11 -> resp_err=1;
  - load at 0x00001000 with ADDR_BITS=10 -> resp_err=1.
- Store word 0x12345678 at 0x20, reset asserted one cycle after acceptance (BUSY) -> next cycle req_ready=1, resp_valid=0; a load word at 0x20 returns the prior contents, not 0x12345678.
- WAIT_CYCLES=0: load accepted at edge N -> resp_valid in the cycle after edge N+1. req_valid held high continuously -> one response every 2 cycles.
